pwm_core: RTL and testbench
===========================

Name: pwm_core

Overview:
Duty-cycle PWM generator that sits directly downstream of the prescaler tick counter in the PWM path. It consumes the prescaler's one-cycle done/tick strobe as its count enable and advances an R-bit phase counter once per tick. It compares the counter against a programmed duty value and drives a registered PWM output with selectable polarity. Period and duty are double-buffered, so software updates take effect only on a period boundary and never glitch the waveform.

Parameters:
R, 8, resolution in bits of the period, duty and phase counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
tick  in  1  count strobe from prescaler done; may be high on consecutive cycles
enable  in  1  run control; 0 = idle
period_in  in  R  requested period minus 1, in ticks
duty_in  in  R  requested high time, in ticks
load  in  1  1-cycle strobe; captures period_in and duty_in into the shadow registers
invert  in  1  output polarity; 1 = active-low waveform
pwm_out  out  1  registered PWM waveform
period_end  out  1  registered 1-cycle pulse per completed period
pending  out  1  shadow holds values not yet applied

Behaviour:
- Reset (async, reset_n=0): cnt, period_q, duty_q, period_sh, duty_sh, pending, pwm_out and period_end all go to 0. Reset applies immediately mid-period; no completion of the period in progress.
- Boundary condition: bnd = enable & tick & (cnt == period_q).
- Counter:
  - enable=0: cnt <= 0.
  - enable=1 and tick=1: cnt <= bnd ? 0 : cnt+1.
  - Otherwise cnt holds.
  - One period = period_q+1 ticks; period_q=0 gives bnd on every tick.
- Shadow and active registers, evaluated per clock in this priority:
  - (a) load & (bnd | ~enable): period_q/duty_q <= period_in/duty_in directly; shadow <= same values; pending <= 0.
  - (b) load only: period_sh/duty_sh <= inputs; pending <= 1. A repeated load overwrites the shadow, last write wins.
  - (c) pending & (bnd | ~enable): period_q/duty_q <= shadow; pending <= 0.
  - A change never takes effect mid-period while enable=1.
- Compare: raw = enable & (cnt < duty_q), unsigned R-bit compare.
  - duty_q=0 gives a constant inactive level.
  - duty_q > period_q gives a constant active level (100%).
  - No wrap or overflow on the compare.
- Output: pwm_out <= raw ^ invert every clock. pwm_out lags cnt by 1 clock.
  - While enable=0, pwm_out settles to invert (the idle level) 1 clock after enable falls.
- period_end <= bnd. It is high exactly 1 clock, in the cycle after the wrap, and is 0 whenever enable=0.
- Enable rising: counting starts from cnt=0 with the already-applied active values. The first tick moves cnt to 1.
- Enable falling mid-period: cnt clears the next clock, no period_end is generated, and pending values apply that same clock.
- tick with enable=0 is ignored.

Test Plan:
- Reset then idle: reset_n low with invert=1 -> pwm_out=0 during reset. Release with enable=0 -> pwm_out=1 after 1 clk, pending=0, period_end=0.
- Basic waveform: load period=9, duty=3 while idle, enable=1, tick every clk -> pwm_out high 3 clks, low 7 clks, repeating. period_end pulses once every 10 clks, in the clk after cnt 9->0.
- Prescaled ticks: tick every 4th clk, period=3, duty=2 -> pwm_out high 8 clks, low 8 clks. period_end spacing = 16 clks.
- Deferred update: running period=9, duty=3; load duty=7 at cnt=5 -> pending=1 and the current period keeps the 3-tick high. The next period shows 7 ticks high, and pending clears on the bnd cycle.
- Boundary collision: load period=4, duty=1 in the exact bnd cycle -> new values apply immediately, pending never rises, and the next period is 5 ticks with 1 high.
- Extremes and abort: duty=0 -> pwm_out constant 0. duty=12 with period=9 -> constant 1. invert=1 flips both. Drop enable at cnt=6 -> cnt=0 next clk, no period_end, pwm_out=invert.

Source files
------------

// File: rtl/pwm_core.sv
// pwm_core: duty-cycle PWM generator driven by a prescaler tick strobe.
// An R-bit phase counter advances once per tick and wraps at the active
// period. The active period/duty pair is double-buffered behind a shadow
// pair, so a software load only takes effect on a period boundary or while idle.
module pwm_core #(
   parameter int unsigned R = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         tick,
   input  logic         enable,
   input  logic [R-1:0] period_in,
   input  logic [R-1:0] duty_in,
   input  logic         load,
   input  logic         invert,
   output logic         pwm_out,
   output logic         period_end,
   output logic         pending
);

   logic [R-1:0] cnt;
   logic [R-1:0] period_q;
   logic [R-1:0] duty_q;
   logic [R-1:0] period_sh;
   logic [R-1:0] duty_sh;
   logic         bnd;
   logic         apply_ok;
   logic         raw;

   // Wrap detection, the "safe to apply new values" window and the raw compare.
   always_comb begin
      bnd      = enable & tick & (cnt == period_q);
      apply_ok = bnd | ~enable;
      raw      = enable & (cnt < duty_q);
   end

   // Phase counter: cleared while idle, advances per tick, wraps at period_q.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (!enable) begin
         cnt <= '0;
      end else if (tick) begin
         if (bnd) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Active/shadow registers. A load landing in the apply window bypasses
   // the shadow; otherwise it parks there until the next window.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         period_q  <= '0;
         duty_q    <= '0;
         period_sh <= '0;
         duty_sh   <= '0;
         pending   <= 1'b0;
      end else if (load && apply_ok) begin
         period_q  <= period_in;
         duty_q    <= duty_in;
         period_sh <= period_in;
         duty_sh   <= duty_in;
         pending   <= 1'b0;
      end else if (load) begin
         period_sh <= period_in;
         duty_sh   <= duty_in;
         pending   <= 1'b1;
      end else if (pending && apply_ok) begin
         period_q  <= period_sh;
         duty_q    <= duty_sh;
         pending   <= 1'b0;
      end
   end

   // Registered outputs: polarity-adjusted waveform and the wrap pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_out    <= 1'b0;
         period_end <= 1'b0;
      end else begin
         pwm_out    <= raw ^ invert;
         period_end <= bnd;
      end
   end

endmodule

// File: tb/tb_pwm_core.sv
// tb_pwm_core: directed bench for pwm_core with hand-computed waveforms.
// Waveforms are captured as bit vectors, bit i = sample after the i-th edge.
module tb_pwm_core;

   logic       clk;
   logic       reset_n;
   logic       tick;
   logic       enable;
   logic [7:0] period_in;
   logic [7:0] duty_in;
   logic       load;
   logic       invert;
   logic       pwm_out;
   logic       period_end;
   logic       pending;

   int unsigned checks;
   int unsigned failures;

   logic [31:0] pv;
   logic [31:0] pe;
   logic [31:0] pd;

   pwm_core #(.R(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick       (tick),
      .enable     (enable),
      .period_in  (period_in),
      .duty_in    (duty_in),
      .load       (load),
      .invert     (invert),
      .pwm_out    (pwm_out),
      .period_end (period_end),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle for one clock while loading new values directly into the active pair.
   task automatic idle_load(input string tag, input logic [7:0] p, input logic [7:0] d, input logic inv);
      enable    = 1'b0;
      tick      = 1'b1;
      invert    = inv;
      load      = 1'b1;
      period_in = p;
      duty_in   = d;
      step();
      load = 1'b0;
      check({tag, "_idle_pwm"}, {31'd0, pwm_out}, {31'd0, inv});
      check({tag, "_idle_pend"}, {31'd0, pending}, 32'd0);
      check({tag, "_idle_pe"}, {31'd0, period_end}, 32'd0);
   endtask

   // Run n clocks with tick every tdiv clocks, optionally loading at sample load_at.
   task automatic run(input int n, input int load_at, input int tdiv,
                      input logic [7:0] p, input logic [7:0] d,
                      output logic [31:0] v_pwm, output logic [31:0] v_pe,
                      output logic [31:0] v_pd);
      v_pwm = '0;
      v_pe  = '0;
      v_pd  = '0;
      for (int i = 0; i < n; i++) begin
         if (i == load_at) begin
            load      = 1'b1;
            period_in = p;
            duty_in   = d;
         end
         tick = ((i % tdiv) == 0);
         step();
         load = 1'b0;
         v_pwm[i] = pwm_out;
         v_pe[i]  = period_end;
         v_pd[i]  = pending;
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      reset_n   = 1'b0;
      tick      = 1'b0;
      enable    = 1'b0;
      period_in = '0;
      duty_in   = '0;
      load      = 1'b0;
      invert    = 1'b1;

      // Reset held across clocks with invert=1: outputs stay at 0.
      step();
      step();
      check("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check("rst_pend", {31'd0, pending}, 32'd0);
      check("rst_pe", {31'd0, period_end}, 32'd0);

      // Release while idle: pwm settles to the idle level one clock later.
      reset_n = 1'b1;
      step();
      check("rel_pwm", {31'd0, pwm_out}, 32'd1);
      check("rel_pend", {31'd0, pending}, 32'd0);
      check("rel_pe", {31'd0, period_end}, 32'd0);

      // Basic: period=9, duty=3, tick every clock.
      idle_load("basic", 8'd9, 8'd3, 1'b0);
      enable = 1'b1;
      run(20, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("basic_pwm", pv, 32'h0001C07);
      check("basic_pe", pe, 32'h0080200);

      // Deferred: duty=7 loaded at cnt=5; current period keeps 3 highs.
      run(20, 5, 1, 8'd9, 8'd7, pv, pe, pd);
      check("defer_pwm", pv, 32'h001FC07);
      check("defer_pend", pd, 32'h00001E0);
      check("defer_pe", pe, 32'h0080200);

      // Collision: load period=4, duty=1 exactly on the wrap cycle.
      run(20, 9, 1, 8'd4, 8'd1, pv, pe, pd);
      check("coll_pwm", pv, 32'h000847F);
      check("coll_pend", pd, 32'h0);
      check("coll_pe", pe, 32'h0084200);

      // Prescaled: tick every 4th clock, period=3, duty=2.
      idle_load("presc", 8'd3, 8'd2, 1'b0);
      enable = 1'b1;
      run(32, -1, 4, 8'd0, 8'd0, pv, pe, pd);
      check("presc_pwm", pv, 32'hE01FE01F);
      check("presc_pe", pe, 32'h10001000);

      // Extremes: duty=0 and duty>period, both polarities.
      idle_load("d0", 8'd9, 8'd0, 1'b0);
      enable = 1'b1;
      run(20, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("d0_pwm", pv, 32'h0);
      check("d0_pe", pe, 32'h0080200);

      idle_load("d12", 8'd9, 8'd12, 1'b0);
      enable = 1'b1;
      run(20, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("d12_pwm", pv, 32'h00FFFFF);

      idle_load("d12i", 8'd9, 8'd12, 1'b1);
      enable = 1'b1;
      run(20, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("d12i_pwm", pv, 32'h0);

      idle_load("d0i", 8'd9, 8'd0, 1'b1);
      enable = 1'b1;
      run(20, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("d0i_pwm", pv, 32'h00FFFFF);

      // Abort: run to cnt=6 with a pending duty=5, then drop enable.
      idle_load("abort", 8'd9, 8'd3, 1'b1);
      enable = 1'b1;
      run(6, 3, 1, 8'd9, 8'd5, pv, pe, pd);
      check("abort_run_pwm", pv, 32'h38);
      check("abort_run_pend", pd, 32'h38);
      check("abort_run_pe", pe, 32'h0);
      enable = 1'b0;
      tick   = 1'b1;
      step();
      check("abort_pwm", {31'd0, pwm_out}, 32'd1);
      check("abort_pe", {31'd0, period_end}, 32'd0);
      check("abort_pend", {31'd0, pending}, 32'd0);

      // Restart: counting begins at cnt=0 with the duty applied on abort.
      enable = 1'b1;
      run(10, -1, 1, 8'd0, 8'd0, pv, pe, pd);
      check("restart_pwm", pv, 32'h3E0);
      check("restart_pe", pe, 32'h200);

      // Asynchronous reset mid-cycle clears outputs without a clock edge.
      #3;
      reset_n = 1'b0;
      #1;
      check("areset_pwm", {31'd0, pwm_out}, 32'd0);
      check("areset_pe", {31'd0, period_end}, 32'd0);
      check("areset_pend", {31'd0, pending}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
